sram6t_ctrl: RTL and testbench
==============================

SRAM6T_CTRL -- requirements
Module: sram6t_ctrl

Interface
REQ-001 Parameter T_PRE, default 2: precharge phase length in clk cycles; legal range 1..15.
REQ-002 Parameter T_WL, default 2: wordline access phase length in clk cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  1  access request; sampled only while ready=1.
REQ-006 we  input  1  1=write, 0=read; qualified by req.
REQ-007 addr  input  4  row address, selects one of 16 wordlines.
REQ-008 wdata  input  8  write data; qualified by req&&we.
REQ-009 SA_OUT  input  8  sense-amp outputs from the 6T column array.
REQ-010 ready  output  1  controller idle, able to accept a request.
REQ-011 rvalid  output  1  one-cycle pulse; rdata valid.
REQ-012 rdata  output  8  read data.
REQ-013 PRE  output  1  bitline precharge enable.
REQ-014 WL  output  16  one-hot row wordlines.
REQ-015 WE_DRV  output  1  bitline write-driver enable.
REQ-016 BL_D  output  8  write-driver data onto BL; BLB is the driver's complement.
REQ-017 SAE  output  1  sense-amp enable.

Function
REQ-018 The FSM SHALL have states IDLE, PRECH, ACCESS, SENSE and RECOVER, plus a 4-bit phase counter.
REQ-019 In IDLE: ready=1, PRE=1, WL=0, WE_DRV=0, SAE=0.
REQ-020 A request is accepted on the rising edge where state=IDLE and req=1; addr, we and wdata SHALL be latched on that edge, and the next state is PRECH.
REQ-021 In PRECH: PRE=1, ready=0, WL=0; stay exactly T_PRE cycles, then go to ACCESS.
REQ-022 In ACCESS: PRE=0, WL[addr_q]=1 and all other WL bits 0, WE_DRV=we_q, BL_D=wdata_q; stay exactly T_WL cycles.
REQ-023 ACCESS exit: a write goes to RECOVER; a read goes to SENSE.
REQ-024 In SENSE (1 cycle): WL[addr_q] stays 1, SAE=1, WE_DRV=0; rdata SHALL capture SA_OUT on the edge that leaves SENSE.
REQ-025 In RECOVER (1 cycle): WL=0, SAE=0, WE_DRV=0, PRE=0; rvalid=1 for a read, 0 for a write; next state is IDLE.
REQ-026 Latency from the accept edge back to ready=1 SHALL be T_PRE+T_WL+2 cycles for a read and T_PRE+T_WL+1 cycles for a write.
REQ-027 rdata SHALL hold its value until the next read capture.
REQ-028 Invariants on every cycle: PRE and any WL bit are never both 1; WL has at most one bit set; WE_DRV and SAE are never both 1.
REQ-029 While ready=0, req, we, addr and wdata SHALL be ignored; there is no queueing.
REQ-030 A request held high through completion SHALL be re-accepted on the first IDLE edge, giving back-to-back accesses with at least one IDLE cycle between them.
REQ-031 BL_D SHALL be 0 whenever WE_DRV=0.
REQ-032 All outputs SHALL be driven from registers or from a decode of registered state only, with no combinational path from inputs to outputs.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, counter=0, WL=0, WE_DRV=0, SAE=0, BL_D=0, rvalid=0, rdata=0, PRE=1 and ready=1, independent of clk.
REQ-034 Reset asserted mid-access SHALL abort the access with no rvalid, and any partially driven row is dropped; a write is not guaranteed complete.
REQ-035 After rst_n rises, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-036 Write with defaults, addr=5, wdata=0xA5: PRE=1 for 2 cycles; then WL=0x0020, WE_DRV=1 and BL_D=0xA5 for 2 cycles; then 1 RECOVER cycle; ready returns 5 cycles after accept; rvalid stays 0.
REQ-037 Read addr=5 with SA_OUT=0xA5: WL=0x0020 for 3 cycles, with SAE=1 in the 3rd; rvalid pulses for 1 cycle with rdata=0xA5; ready returns 6 cycles after accept.
REQ-038 req held high with alternating addr during a busy period: only the accept-edge addr is used; the invariants of REQ-028 are checked by assertion on every cycle.
REQ-039 rst_n pulsed low in the 2nd ACCESS cycle of a read: WL=0, SAE=0 and PRE=1 with no clk edge; no rvalid; ready=1.
REQ-040 T_PRE=1, T_WL=1, addr=15 read: WL=0x8000, and ready returns 4 cycles after accept.
REQ-041 Back-to-back write then read with req held high: exactly one IDLE cycle between the two operations.

Source files
------------

// File: rtl/sram6t_ctrl.sv
// Access sequencer for a 16-row x 8-bit 6T SRAM column array.
// Per access: precharge, wordline access, sense (reads only), then recover.
module sram6t_ctrl #(
  parameter int unsigned T_PRE = 2,
  parameter int unsigned T_WL  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  SA_OUT,
  output logic        ready,
  output logic        rvalid,
  output logic [7:0]  rdata,
  output logic        PRE,
  output logic [15:0] WL,
  output logic        WE_DRV,
  output logic [7:0]  BL_D,
  output logic        SAE
);

  localparam logic [3:0] PreLast = 4'(T_PRE - 1);
  localparam logic [3:0] WlLast  = 4'(T_WL - 1);

  typedef enum logic [2:0] {StIdle, StPrech, StAccess, StSense, StRecover} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_addr;
  logic        r_we;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        w_accept;
  logic [15:0] w_row;

  assign w_accept = (r_state == StIdle) && req;
  assign w_row    = 16'(1) << r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle: begin
        if (req) begin
          w_state_nxt = StPrech;
          w_cnt_nxt   = '0;
        end
      end
      StPrech: begin
        if (r_cnt == PreLast) begin
          w_state_nxt = StAccess;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StAccess: begin
        if (r_cnt == WlLast) begin
          w_state_nxt = r_we ? StRecover : StSense;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StSense:   w_state_nxt = StRecover;
      StRecover: w_state_nxt = StIdle;
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
      end
      if (r_state == StSense) begin
        r_rdata <= SA_OUT;
      end
    end
  end

  // Outputs are a pure decode of registered state, so reset clears them without a clock.
  always_comb begin
    ready  = 1'b0;
    PRE    = 1'b0;
    WL     = '0;
    WE_DRV = 1'b0;
    BL_D   = '0;
    SAE    = 1'b0;
    rvalid = 1'b0;
    case (r_state)
      StIdle: begin
        ready = 1'b1;
        PRE   = 1'b1;
      end
      StPrech: PRE = 1'b1;
      StAccess: begin
        WL     = w_row;
        WE_DRV = r_we;
        BL_D   = r_we ? r_wdata : 8'h00;
      end
      StSense: begin
        WL  = w_row;
        SAE = 1'b1;
      end
      StRecover: rvalid = ~r_we;
      default: begin
        ready = 1'b1;
        PRE   = 1'b1;
      end
    endcase
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_sram6t_ctrl.sv
// Scoreboard bench for sram6t_ctrl: random accesses against a behavioural memory model,
// plus reset-abort and minimum-timing scenarios.
module tb_sram6t_ctrl;

  localparam int unsigned P_PRE = 2;
  localparam int unsigned P_WL  = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we;
  logic [3:0]  addr;
  logic [7:0]  wdata, sa_out, rdata, bl_d;
  logic        ready, rvalid, pre, we_drv, sae;
  logic [15:0] wl;

  logic        f_req, f_we;
  logic [3:0]  f_addr;
  logic [7:0]  f_wdata, f_sa, f_rdata, f_bl_d;
  logic        f_ready, f_rvalid, f_pre, f_we_drv, f_sae;
  logic [15:0] f_wl;

  sram6t_ctrl #(.T_PRE(P_PRE), .T_WL(P_WL)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .SA_OUT(sa_out), .ready(ready), .rvalid(rvalid), .rdata(rdata), .PRE(pre),
    .WL(wl), .WE_DRV(we_drv), .BL_D(bl_d), .SAE(sae)
  );

  sram6t_ctrl #(.T_PRE(1), .T_WL(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
    .SA_OUT(f_sa), .ready(f_ready), .rvalid(f_rvalid), .rdata(f_rdata), .PRE(f_pre),
    .WL(f_wl), .WE_DRV(f_we_drv), .BL_D(f_bl_d), .SAE(f_sae)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Column array environment: rows are written through the bitline drivers, read via SA_OUT.
  logic [7:0] cells [16];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) cells[i] <= 8'(i * 37 + 11);
      mem_init <= 1'b1;
    end else if (we_drv) begin
      for (int i = 0; i < 16; i++) if (wl[i]) cells[i] <= bl_d;
    end
  end
  always_comb begin
    sa_out = 8'h00;
    for (int i = 0; i < 16; i++) if (wl[i]) sa_out = cells[i];
  end

  // Reference model and scoreboard queues.
  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    int         acc_cyc;
  } txn_t;

  logic [7:0] ref_mem [16];
  txn_t       txn_q [$];
  logic [7:0] rd_q [$];

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input logic hold);
    int   guard = 0;
    txn_t t;
    while (!ready && guard < 100) begin
      req   = hold ? 1'b1 : 1'($urandom);
      we    = 1'($urandom);
      addr  = 4'($urandom);
      wdata = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
    end else begin
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      t.we      = w;
      t.addr    = a;
      t.data    = d;
      t.acc_cyc = cyc + 1;
      txn_q.push_back(t);
      if (w) ref_mem[a] = d;
      else   rd_q.push_back(ref_mem[a]);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: invariants every cycle, per-transaction phase accounting, read data compare.
  logic prev_ready = 1'b1;
  logic prev_req   = 1'b0;
  int   pre_n = 0, wl_n = 0, sae_n = 0, drv_n = 0;
  always begin
    txn_t cur;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_ready = 1'b1;
      prev_req   = 1'b0;
      pre_n = 0; wl_n = 0; sae_n = 0; drv_n = 0;
    end else begin
      check("inv_pre_wl", 32'(pre && (wl != 16'h0)), 32'd0);
      check("inv_wl_onehot", 32'($countones(wl) <= 1), 32'd1);
      check("inv_drv_sae", 32'(we_drv && sae), 32'd0);
      check("inv_bld_idle", 32'(!we_drv && (bl_d != 8'h00)), 32'd0);
      if (rvalid) begin
        if (rd_q.size() == 0) check("rvalid_unexpected", 32'(rvalid), 32'd0);
        else                  check("rdata", 32'(rdata), 32'(rd_q.pop_front()));
      end
      if (prev_ready && prev_req) check("accept", 32'(ready), 32'd0);
      if (!ready) begin
        if (txn_q.size() == 0) begin
          check("busy_without_txn", 32'(ready), 32'd1);
        end else begin
          cur = txn_q[0];
          if (pre)    pre_n++;
          if (sae)    sae_n++;
          if (we_drv) drv_n++;
          if (wl != 16'h0) begin
            wl_n++;
            check("wl_row", 32'(wl), 32'(16'(1) << cur.addr));
          end
          if (we_drv) begin
            check("drv_on_write", 32'(cur.we), 32'd1);
            check("bl_d", 32'(bl_d), 32'(cur.data));
          end
        end
      end else if (!prev_ready) begin
        if (txn_q.size() == 0) begin
          check("ready_without_txn", 32'(txn_q.size()), 32'd1);
        end else begin
          cur = txn_q.pop_front();
          check("latency", 32'(cyc - cur.acc_cyc), 32'(P_PRE + P_WL + (cur.we ? 1 : 2)));
          check("pre_cycles", 32'(pre_n), 32'(P_PRE));
          check("wl_cycles", 32'(wl_n), 32'(P_WL + (cur.we ? 0 : 1)));
          check("sae_cycles", 32'(sae_n), cur.we ? 32'd0 : 32'd1);
          check("drv_cycles", 32'(drv_n), cur.we ? 32'(P_WL) : 32'd0);
        end
        pre_n = 0; wl_n = 0; sae_n = 0; drv_n = 0;
      end
      prev_ready = ready;
      prev_req   = req;
    end
  end

  initial begin
    int k, fwl_n, frv_n, guard;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0; f_sa = 8'h3C;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_pre", 32'(pre), 32'd1);
    check("rst_wl", 32'(wl), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_bl_d", 32'(bl_d), 32'd0);
    check("rst_drv_sae", 32'({we_drv, sae}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read row 5 back-to-back with req held high throughout.
    issue(1'b1, 4'd5, 8'hA5, 1'b1);
    issue(1'b0, 4'd5, 8'h00, 1'b1);
    issue(1'b0, 4'd5, 8'h00, 1'b1);
    idle(1);

    repeat (60) begin
      issue(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    req = 1'b0;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    idle(3);

    // Reset pulse in the second wordline cycle of a read.
    issue(1'b0, 4'd3, 8'h00, 1'b0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_wl", 32'(wl), 32'd0);
    check("abort_sae", 32'(sae), 32'd0);
    check("abort_pre", 32'(pre), 32'd1);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_rvalid", 32'(rvalid), 32'd0);
    txn_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 4'd9, 8'h00, 1'b0);
    idle(10);

    // Minimum timing: T_PRE=1, T_WL=1, read row 15.
    f_req = 1'b1; f_we = 1'b0; f_addr = 4'd15;
    @(negedge clk);
    f_req = 1'b0;
    k = 1; fwl_n = 0; frv_n = 0;
    while (!f_ready && k < 12) begin
      if (f_wl != 16'h0) begin
        fwl_n++;
        check("fast_wl", 32'(f_wl), 32'h8000);
      end
      if (f_rvalid) begin
        frv_n++;
        check("fast_rdata", 32'(f_rdata), 32'h3C);
      end
      @(negedge clk);
      k++;
    end
    check("fast_latency", 32'(k - 1), 32'd4);
    check("fast_wl_cycles", 32'(fwl_n), 32'd2);
    check("fast_rvalid_cycles", 32'(frv_n), 32'd1);

    check("txn_q_drained", 32'(txn_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
